// File: rtl/mash_frac_decoder.sv
// Recovers the integer and 24-bit fraction of a MASH modulator by averaging 2^W output samples.
// Optional min/max sample tracking is enabled with the MASH_DECODE_MINMAX_EN macro.
module mash_frac_decoder #(
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_sample_en,
  input  logic [7:0] i_mash_out,
  input  logic [1:0] i_win_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_int,
  output logic [7:0] o_msb,
  output logic [7:0] o_isb,
`ifdef MASH_DECODE_MINMAX_EN
  output logic [7:0] o_lsb,
  output logic [7:0] o_min,
  output logic [7:0] o_max
`else
  output logic [7:0] o_lsb
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StAccum, StDone} state_e;

  state_e      state_q, state_d;
  logic [24:0] cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  win_q, win_d;
  logic        load;
  logic        restart;

  logic [24:0] cnt_inc;
  logic [31:0] acc_sum;
  logic [4:0]  win_bits;
  logic [24:0] win_len;
  logic [7:0]  int_val;
  logic [23:0] frac_val;

  always_comb begin
    cnt_inc  = cnt_q + 25'd1;
    acc_sum  = acc_q + {24'd0, i_mash_out};
    win_bits = 5'd12 + {1'b0, win_q, 2'b00};
    win_len  = 25'd1 << win_bits;
    int_val  = 8'(acc_sum >> win_bits);
    // Left-justify the fractional bits so the fraction is always 24 bits wide.
    frac_val = acc_sum[23:0] << (5'd24 - win_bits);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    win_d   = win_q;
    load    = 1'b0;
    restart = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) restart = 1'b1;
      end
      StSettle: begin
        if (i_start) begin
          restart = 1'b1;
        end else if (i_sample_en) begin
          if (cnt_inc == 25'(SETTLE_CYC)) begin
            state_d = StAccum;
            cnt_d   = 25'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StAccum: begin
        if (i_start) begin
          restart = 1'b1;
        end else if (i_sample_en) begin
          acc_d = acc_sum;
          if (cnt_inc == win_len) begin
            state_d = StDone;
            load    = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (i_start) restart = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (restart) begin
      cnt_d   = 25'd0;
      acc_d   = 32'd0;
      win_d   = i_win_sel;
      state_d = (SETTLE_CYC == 0) ? StAccum : StSettle;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= 25'd0;
      acc_q   <= 32'd0;
      win_q   <= 2'd0;
      o_int   <= 8'd0;
      o_msb   <= 8'd0;
      o_isb   <= 8'd0;
      o_lsb   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      if (load) begin
        o_int <= int_val;
        o_msb <= frac_val[23:16];
        o_isb <= frac_val[15:8];
        o_lsb <= frac_val[7:0];
      end
    end
  end

  assign o_busy = (state_q == StSettle) || (state_q == StAccum);
  assign o_done = (state_q == StDone);

`ifdef MASH_DECODE_MINMAX_EN
  logic [7:0] min_q, min_d;
  logic [7:0] max_q, max_d;
  logic       take;

  always_comb begin
    take  = (state_q == StAccum) && i_sample_en && !i_start;
    min_d = min_q;
    max_d = max_q;
    if (take) begin
      // The first accumulated sample seeds both trackers.
      if (cnt_q == 25'd0) begin
        min_d = i_mash_out;
        max_d = i_mash_out;
      end else begin
        if (i_mash_out < min_q) min_d = i_mash_out;
        if (i_mash_out > max_q) max_d = i_mash_out;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      min_q <= 8'd0;
      max_q <= 8'd0;
      o_min <= 8'd0;
      o_max <= 8'd0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      if (load) begin
        o_min <= min_d;
        o_max <= max_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mash_frac_decoder.sv
// Scoreboard bench for mash_frac_decoder: a sample-count model predicts each result,
// a negedge monitor compares results, hold behaviour and busy.
module tb_mash_frac_decoder;

  localparam int unsigned SETTLE = 8;

  logic       clk = 1'b0;
  logic       i_rst, i_start, i_sample_en;
  logic [7:0] i_mash_out;
  logic [1:0] i_win_sel;
  logic       o_busy, o_done;
  logic [7:0] o_int, o_msb, o_isb, o_lsb;
`ifdef MASH_DECODE_MINMAX_EN
  logic [7:0] o_min, o_max;
`endif

  always #5 clk = ~clk;

  mash_frac_decoder #(.SETTLE_CYC(SETTLE)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_sample_en (i_sample_en),
    .i_mash_out  (i_mash_out),
    .i_win_sel   (i_win_sel),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_int       (o_int),
    .o_msb       (o_msb),
    .o_isb       (o_isb),
`ifdef MASH_DECODE_MINMAX_EN
    .o_lsb       (o_lsb),
    .o_min       (o_min),
    .o_max       (o_max)
`else
    .o_lsb       (o_lsb)
`endif
  );

  typedef struct {
    int unsigned cyc;
    int unsigned iv;
    int unsigned frac;
    int unsigned mn;
    int unsigned mx;
  } exp_t;

  exp_t        q[$];
  exp_t        held;
  exp_t        mon_e;
  int          nchecks = 0;
  int          nfail = 0;
  int unsigned cyc = 0;
  int          pushes = 0;

  // Reference model: counts qualified samples since the last start.
  bit          m_active = 1'b0;
  int unsigned m_n = 0;
  int unsigned m_w = 12;
  longint      m_sum = 0;
  int unsigned m_min = 255;
  int unsigned m_max = 0;

  task automatic check(input string name, input longint act, input longint req);
    nchecks++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] sample_val(input int dmode, input int unsigned n);
    case (dmode)
      0:       return 8'd100;
      1:       return (n % 2 == 1) ? 8'd6 : 8'd5;
      2:       return 8'($urandom_range(0, 255));
      default: return 8'(3 + (n % 4));
    endcase
  endfunction

  task automatic push_result();
    exp_t        e;
    longint      n_win;
    longint      whole;
    n_win  = longint'(1) << m_w;
    whole  = m_sum / n_win;
    e.cyc  = cyc;
    e.iv   = int'(whole);
    e.frac = int'(((m_sum - whole * n_win) * (longint'(1) << 24)) / n_win);
    e.mn   = m_min;
    e.mx   = m_max;
    q.push_back(e);
    pushes++;
  endtask

  task automatic step(input bit rst, input bit start, input bit en, input logic [1:0] ws,
                      input logic [7:0] d);
    i_rst       = rst;
    i_start     = start;
    i_sample_en = en;
    i_win_sel   = ws;
    i_mash_out  = d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_n      = 0;
      held     = '{default: 0};
    end else if (start) begin
      m_active = 1'b1;
      m_n      = 0;
      m_sum    = 0;
      m_w      = 12 + 4 * int'(ws);
      m_min    = 255;
      m_max    = 0;
    end else if (m_active && en) begin
      m_n++;
      if (m_n > SETTLE) begin
        m_sum += longint'(d);
        if (d < m_min) m_min = d;
        if (d > m_max) m_max = d;
      end
      if (m_n == SETTLE + (1 << m_w)) begin
        push_result();
        m_active = 1'b0;
      end
    end
    #1;
  endtask

  // n_qual < 0 runs until the model predicts completion.
  task automatic run(input int n_qual, input int en_mode, input int dmode, input logic [1:0] ws);
    int target;
    int got;
    int budget;
    bit en;
    target = pushes + 1;
    got    = 0;
    budget = (n_qual < 0) ? 3 * int'(SETTLE + (1 << m_w)) + 50 : 3 * n_qual + 50;
    for (int i = 0; i < budget; i++) begin
      if (n_qual >= 0 && got >= n_qual) break;
      if (n_qual < 0 && pushes >= target) break;
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (i % 2 == 0);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      step(1'b0, 1'b0, en, ws, sample_val(dmode, m_n));
      if (en) got++;
    end
    if (n_qual < 0) check("completion_within_budget", longint'(pushes >= target), 1);
  endtask

  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      if (q.size() == 0) begin
        nchecks++;
        nfail++;
        $display("FAIL unexpected_done: o_done high at cycle %0d with no result due", cyc);
      end else begin
        mon_e = q.pop_front();
        check("done_cycle", longint'(cyc), longint'(mon_e.cyc));
        check("o_int", longint'(o_int), longint'(mon_e.iv));
        check("fraction", longint'({o_msb, o_isb, o_lsb}), longint'(mon_e.frac));
`ifdef MASH_DECODE_MINMAX_EN
        check("o_min", longint'(o_min), longint'(mon_e.mn));
        check("o_max", longint'(o_max), longint'(mon_e.mx));
`endif
        held = mon_e;
      end
    end else begin
      check("held_int", longint'(o_int), longint'(held.iv));
      check("held_fraction", longint'({o_msb, o_isb, o_lsb}), longint'(held.frac));
`ifdef MASH_DECODE_MINMAX_EN
      check("held_min", longint'(o_min), longint'(held.mn));
      check("held_max", longint'(o_max), longint'(held.mx));
`endif
    end
    check("o_busy", longint'(o_busy), longint'(m_active));
  end

  initial begin
    held = '{default: 0};
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    // Constant DC over a 2^12 window.
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    run(-1, 0, 0, 2'd0);

    // Start during DONE, then the same DC run with a toggling enable.
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'd100);
    run(-1, 1, 0, 2'd0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    // Restart after 2000 accumulated samples, coincident with a valid sample.
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    run(int'(SETTLE) + 2000, 2, 2, 2'd0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 8'($urandom_range(0, 255)));
    // Window select changes after start must be ignored.
    run(-1, 2, 2, 2'd3);
    repeat (2) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    // Reset mid-run, asserted together with start and a valid sample.
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    run(1000, 0, 2, 2'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0, 8'd50);
    repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);

    // Alternating 5,6 over a 2^16 window.
    step(1'b0, 1'b1, 1'b0, 2'd1, 8'd0);
    run(-1, 0, 1, 2'd1);

`ifdef MASH_DECODE_MINMAX_EN
    // Cycling 3,4,5,6 for min/max tracking.
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    run(-1, 0, 3, 2'd0);
`endif

    repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    check("results_outstanding", longint'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/mash_frac_decoder.md
MASH_FRAC_DECODER -- requirements
Module: mash_frac_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 8: number of qualified samples discarded after start, covering modulator pipeline fill.
REQ-002 SHALL have ports i_clk, input, 1: single clock for all logic.
REQ-003 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port i_start, input, 1: single-cycle pulse that begins a measurement.
REQ-005 SHALL have port i_sample_en, input, 1: qualifies i_mash_out in the current cycle.
REQ-006 SHALL have port i_mash_out, input, 8: unsigned modulator output sample (int+frac).
REQ-007 SHALL have port i_win_sel, input, 2: window length 2^W with W = 12, 16, 20 or 24 for codes 0 to 3.
REQ-008 SHALL have port o_busy, output, 1: high during SETTLE and ACCUM.
REQ-009 SHALL have port o_done, output, 1: one-cycle pulse when results update.
REQ-010 SHALL have ports o_int, o_msb, o_isb and o_lsb, output, 8 each: recovered integer and 24-bit fraction.

Function
REQ-011 SHALL implement FSM states IDLE, SETTLE, ACCUM and DONE.
REQ-012 IDLE to SETTLE SHALL occur on i_start, which latches i_win_sel as W_lat and clears the sample counter and the 32-bit accumulator.
REQ-013 SETTLE SHALL count qualified samples without accumulating them, and go to ACCUM after SETTLE_CYC of them; SETTLE_CYC=0 SHALL go directly to ACCUM.
REQ-014 ACCUM SHALL add i_mash_out, zero-extended, to the accumulator on each qualified cycle.
REQ-015 ACCUM SHALL go to DONE when the 2^W_lat-th sample is added; that sample is included in the sum.
REQ-016 DONE SHALL last exactly one cycle, then go to IDLE.
REQ-017 In DONE, o_done SHALL be 1 and the outputs SHALL load from the final sum: o_int = sum[W_lat+7:W_lat].
REQ-018 In DONE, {o_msb,o_isb,o_lsb} SHALL load sum[W_lat-1:0] shifted left by (24-W_lat).
REQ-019 Results SHALL be held until the next DONE or reset.
REQ-020 The result SHALL be visible in the cycle after the last qualified sample (registered outputs, latency 1).
REQ-021 A deasserted i_sample_en SHALL stall the counter and accumulator in any state; there is no timeout.
REQ-022 i_start in SETTLE or ACCUM SHALL restart the measurement: clear, re-latch i_win_sel, enter SETTLE, and leave the held outputs unchanged.
REQ-023 i_start in DONE SHALL be honoured: DONE completes and the next state is SETTLE instead of IDLE.
REQ-024 i_start and the final sample in the same ACCUM cycle: restart SHALL win, with no o_done and no output update.
REQ-025 The accumulator SHALL be 32 bits; 255*2^24 < 2^32, so no overflow occurs by construction.
REQ-026 The sample counter SHALL be 25 bits wide, so 2^24 is representable.
REQ-027 i_win_sel changes after start SHALL have no effect.

Reset
REQ-028 i_rst, sampled on the i_clk edge, SHALL force IDLE and clear the counter and accumulator.
REQ-029 On reset, o_busy=0, o_done=0 and o_int, o_msb, o_isb and o_lsb SHALL all be 0.
REQ-030 Reset SHALL take priority over i_start and i_sample_en.
REQ-031 Reset mid-measurement SHALL abort without asserting o_done.

Configuration
REQ-032 With macro MASH_DECODE_MINMAX_EN defined, the block SHALL add outputs o_min and o_max, 8 bits each.
REQ-033 With MASH_DECODE_MINMAX_EN defined, o_min and o_max SHALL be the extreme ACCUM samples, loaded in DONE, reset to 0, and held like the other results.
REQ-034 Internal trackers SHALL init on the first ACCUM sample.
REQ-035 Without MASH_DECODE_MINMAX_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Constant DC: win_sel=0, i_mash_out=100 constant, sample_en=1 -> o_done 1 cycle after sample 8+4096; o_int=100, fraction=0.
REQ-037 Alternating pattern: win_sel=1, samples alternate 5,6 -> o_int=5, o_msb=0x80, o_isb=0, o_lsb=0.
REQ-038 Stall: win_sel=0, sample_en toggles 1/0 -> exactly 4104 qualified samples consumed, o_done 1 cycle after the 4104th, same result as the unstalled run.
REQ-039 Restart: i_start pulsed again at sample 2000 of ACCUM -> no o_done; new run completes 4104 qualified samples later; prior outputs held meanwhile.
REQ-040 Reset mid-run: i_rst at sample 1000 -> IDLE, all outputs 0, no o_done.
REQ-041 MinMax build: win_sel=0, samples cycling 3,4,5,6 -> o_int=4, o_msb=0x80, o_min=3, o_max=6.
